// File: rtl/icache_axi_responder_pkg.sv
// Shared types for the instruction-cache AXI read responder.
package icache_axi_responder_pkg;

    localparam int unsigned AXI_LEN_W = 8;
    localparam int unsigned LAT_W     = 4;

    localparam logic [2:0] AXI_SIZE_WORD = 3'b010;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } axi_burst_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_BURST
    } resp_state_e;

    // WRAP bursts are only defined for 2, 4, 8 or 16 beats.
    function automatic logic wrap_len_ok(input logic [AXI_LEN_W-1:0] len);
        return len inside {8'd1, 8'd3, 8'd7, 8'd15};
    endfunction

endpackage

// File: rtl/icache_axi_responder_mem.sv
// Word array with one synchronous write port and one synchronous read port.
// The read register doubles as the R-channel beat holding register.
module axi_resp_mem #(
    parameter int unsigned DEPTH = 4096,
    parameter int unsigned WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    input  logic                     rzero,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read returns pre-write contents on a same-cycle collision.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= rzero ? '0 : mem[raddr];
        end
    end

endmodule

// File: rtl/icache_axi_responder.sv
// AXI4 read-only responder for the instruction-cache refill port: one request
// in flight, fixed programmable latency, bursts served from an internal array.
module icache_axi_responder
    import icache_axi_responder_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned ID_WIDTH     = 1,
    parameter int unsigned MEM_DEPTH    = 4096,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ar_valid,
    output logic                         ar_ready,
    input  logic [ID_WIDTH-1:0]          ar_id,
    input  logic [ADDR_WIDTH-1:0]        ar_addr,
    input  logic [7:0]                   ar_len,
    input  logic [2:0]                   ar_size,
    input  logic [1:0]                   ar_burst,
    output logic                         r_valid,
    input  logic                         r_ready,
    output logic [ID_WIDTH-1:0]          r_id,
    output logic [DATA_WIDTH-1:0]        r_data,
    output logic [1:0]                   r_resp,
    output logic                         r_last,
    input  logic                         bd_we,
    input  logic [$clog2(MEM_DEPTH)-1:0] bd_addr,
    input  logic [DATA_WIDTH-1:0]        bd_wdata
);

    localparam int unsigned IDX_W = $clog2(MEM_DEPTH);
    localparam int unsigned WA_W  = ADDR_WIDTH - 2;
    localparam logic [LAT_W-1:0] LAT_LOAD =
        (READ_LATENCY == 0) ? '0 : LAT_W'(READ_LATENCY - 1);

    resp_state_e          state_q, state_d;
    logic [LAT_W-1:0]     lat_q, lat_d;
    logic [ID_WIDTH-1:0]  id_q, id_d;
    logic [WA_W-1:0]      waddr_q, waddr_d;
    logic [AXI_LEN_W-1:0] len_q, len_d;
    axi_burst_e           burst_q, burst_d;
    logic                 slverr_q, slverr_d;
    logic [AXI_LEN_W-1:0] beat_q, beat_d;
    logic                 r_valid_q, r_valid_d;
    logic                 r_last_q, r_last_d;
    axi_resp_e            r_resp_q, r_resp_d;
    logic                 ar_ready_q, ar_ready_d;
    logic                 load;
    logic                 decerr;
    logic                 beat_zero;

    // Word address of the beat after `cur`; WRAP keeps the upper bits of the
    // (len+1)-aligned window and rolls only the low bits.
    function automatic logic [WA_W-1:0] next_waddr(
        input logic [WA_W-1:0]      cur,
        input logic [AXI_LEN_W-1:0] len,
        input axi_burst_e           burst
    );
        logic [WA_W-1:0] mask;
        logic [WA_W-1:0] inc;
        mask = WA_W'(len);
        inc  = cur + WA_W'(1);
        case (burst)
            BURST_INCR: next_waddr = inc;
            BURST_WRAP: next_waddr = (cur & ~mask) | (inc & mask);
            default:    next_waddr = cur;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            lat_q      <= '0;
            id_q       <= '0;
            waddr_q    <= '0;
            len_q      <= '0;
            burst_q    <= BURST_FIXED;
            slverr_q   <= 1'b0;
            beat_q     <= '0;
            r_valid_q  <= 1'b0;
            r_last_q   <= 1'b0;
            r_resp_q   <= RESP_OKAY;
            ar_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lat_q      <= lat_d;
            id_q       <= id_d;
            waddr_q    <= waddr_d;
            len_q      <= len_d;
            burst_q    <= burst_d;
            slverr_q   <= slverr_d;
            beat_q     <= beat_d;
            r_valid_q  <= r_valid_d;
            r_last_q   <= r_last_d;
            r_resp_q   <= r_resp_d;
            ar_ready_q <= ar_ready_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        lat_d     = lat_q;
        id_d      = id_q;
        waddr_d   = waddr_q;
        len_d     = len_q;
        burst_d   = burst_q;
        slverr_d  = slverr_q;
        beat_d    = beat_q;
        r_valid_d = r_valid_q;
        r_last_d  = r_last_q;
        r_resp_d  = r_resp_q;
        load      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ar_valid && ar_ready_q) begin
                    id_d     = ar_id;
                    waddr_d  = WA_W'(ar_addr >> 2);
                    len_d    = ar_len;
                    burst_d  = axi_burst_e'(ar_burst);
                    slverr_d = (ar_size != AXI_SIZE_WORD) ||
                               (axi_burst_e'(ar_burst) == BURST_RSVD) ||
                               ((axi_burst_e'(ar_burst) == BURST_WRAP) && !wrap_len_ok(ar_len));
                    beat_d   = '0;
                    lat_d    = LAT_LOAD;
                    if (READ_LATENCY == 0) begin
                        state_d = ST_BURST;
                        load    = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (lat_q == '0) begin
                    state_d = ST_BURST;
                    load    = 1'b1;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            ST_BURST: begin
                if (r_ready) begin
                    if (r_last_q) begin
                        state_d   = ST_IDLE;
                        r_valid_d = 1'b0;
                        r_last_d  = 1'b0;
                    end else begin
                        waddr_d = next_waddr(waddr_q, len_q, burst_q);
                        beat_d  = beat_q + AXI_LEN_W'(1);
                        load    = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Range check uses the full word index, not just the array bits.
        decerr    = |(waddr_d >> IDX_W);
        beat_zero = slverr_d || decerr;

        if (load) begin
            r_valid_d = 1'b1;
            r_last_d  = (beat_d == len_d);
            r_resp_d  = slverr_d ? RESP_SLVERR : (decerr ? RESP_DECERR : RESP_OKAY);
        end

        ar_ready_d = (state_d == ST_IDLE);
    end

    axi_resp_mem #(
        .DEPTH (MEM_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (bd_we),
        .waddr (bd_addr),
        .wdata (bd_wdata),
        .re    (load),
        .raddr (waddr_d[IDX_W-1:0]),
        .rzero (beat_zero),
        .rdata (r_data)
    );

    assign ar_ready = ar_ready_q;
    assign r_valid  = r_valid_q;
    assign r_last   = r_last_q;
    assign r_resp   = r_resp_q;
    assign r_id     = id_q;

endmodule

// File: tb/tb_icache_axi_responder.sv
// Scoreboard bench for icache_axi_responder: randomized bursts against a
// behavioural memory/response model, plus latency-0 and mid-burst reset cases.
module tb_icache_axi_responder;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 32;
    localparam int unsigned IW    = 1;
    localparam int unsigned DEPTH = 4096;
    localparam int unsigned IDXW  = 12;
    localparam int unsigned LAT   = 2;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic        id;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic            ar_valid, ar_ready, r_valid, r_ready, r_last, bd_we;
    logic [IW-1:0]   ar_id, r_id;
    logic [AW-1:0]   ar_addr;
    logic [7:0]      ar_len;
    logic [2:0]      ar_size;
    logic [1:0]      ar_burst, r_resp;
    logic [DW-1:0]   r_data, bd_wdata;
    logic [IDXW-1:0] bd_addr;

    logic            l0_ar_valid, l0_ar_ready, l0_r_valid, l0_r_ready, l0_r_last, l0_bd_we;
    logic [IW-1:0]   l0_ar_id, l0_r_id;
    logic [AW-1:0]   l0_ar_addr;
    logic [7:0]      l0_ar_len;
    logic [2:0]      l0_ar_size;
    logic [1:0]      l0_ar_burst, l0_r_resp;
    logic [DW-1:0]   l0_r_data, l0_bd_wdata;
    logic [IDXW-1:0] l0_bd_addr;

    logic [31:0] ref_mem [DEPTH];
    exp_t        exp_q[$];
    exp_t        mon_e;

    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   t_ar = 0;
    int   rdy_mode = 0;
    int   rdy_ph = 0;
    logic mon_en = 1'b0;
    logic first_pending = 1'b0;
    logic chk_ready = 1'b0;

    icache_axi_responder #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .MEM_DEPTH(DEPTH), .READ_LATENCY(LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_id(ar_id), .ar_addr(ar_addr),
        .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
        .r_valid(r_valid), .r_ready(r_ready), .r_id(r_id), .r_data(r_data),
        .r_resp(r_resp), .r_last(r_last),
        .bd_we(bd_we), .bd_addr(bd_addr), .bd_wdata(bd_wdata)
    );

    icache_axi_responder #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .MEM_DEPTH(DEPTH), .READ_LATENCY(0)
    ) dut_l0 (
        .clk(clk), .rst(rst),
        .ar_valid(l0_ar_valid), .ar_ready(l0_ar_ready), .ar_id(l0_ar_id), .ar_addr(l0_ar_addr),
        .ar_len(l0_ar_len), .ar_size(l0_ar_size), .ar_burst(l0_ar_burst),
        .r_valid(l0_r_valid), .r_ready(l0_r_ready), .r_id(l0_r_id), .r_data(l0_r_data),
        .r_resp(l0_r_resp), .r_last(l0_r_last),
        .bd_we(l0_bd_we), .bd_addr(l0_bd_addr), .bd_wdata(l0_bd_wdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic ok, input string detail);
        n_cmp++;
        if (ok !== 1'b1) begin
            n_fail++;
            $display("FAIL %s: %s", name, detail);
        end
    endfunction

    // Reference: every beat of a request, computed from the AXI burst rules.
    function automatic void push_burst(input logic [31:0] addr, input logic [7:0] len,
                                       input logic [2:0] size, input logic [1:0] burst,
                                       input logic id);
        int     n;
        longint s;
        bit     slv;
        n   = int'(len) + 1;
        s   = longint'(addr >> 2);
        slv = (size != 3'b010) || (burst == 2'b11) ||
              (burst == 2'b10 && !(n == 2 || n == 4 || n == 8 || n == 16));
        for (int i = 0; i < n; i++) begin
            longint w;
            exp_t   e;
            case (burst)
                2'b00:   w = s;
                2'b10:   w = (s - (s % n)) + (((s % n) + i) % n);
                default: w = (s + i) % (longint'(1) << 30);
            endcase
            e.id   = id;
            e.last = (i == n - 1);
            if (slv) begin
                e.resp = 2'b10;
                e.data = 32'h0;
            end else if (w >= DEPTH) begin
                e.resp = 2'b11;
                e.data = 32'h0;
            end else begin
                e.resp = 2'b00;
                e.data = ref_mem[int'(w)];
            end
            exp_q.push_back(e);
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bd_write(input int unsigned w, input logic [31:0] d);
        ref_mem[w] = d;
        bd_we      = 1'b1;
        bd_addr    = IDXW'(w);
        bd_wdata   = d;
        step();
        bd_we      = 1'b0;
    endtask

    task automatic issue(input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input logic id);
        bit got;
        got = 0;
        push_burst(addr, len, size, burst, id);
        ar_valid = 1'b1;
        ar_addr  = addr;
        ar_len   = len;
        ar_size  = size;
        ar_burst = burst;
        ar_id    = id;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            if (ar_ready === 1'b1) got = 1;
            step();
        end
        ar_valid = 1'b0;
        if (!got) begin
            check("ar_handshake_timeout", 1'b0, $sformatf("ar_ready=%b want 1 within 100 cycles", ar_ready));
            exp_q.delete();
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 2000) begin
            step();
            k++;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", 1'b0, $sformatf("%0d beats outstanding, want 0", exp_q.size()));
            exp_q.delete();
        end
        step();
        step();
    endtask

    // Ready pattern generator: always, 1-0-0-1 repeating, or random.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: r_ready = 1'b1;
            1: begin
                r_ready = (rdy_ph == 0) || (rdy_ph == 3);
                rdy_ph  = (rdy_ph + 1) % 4;
            end
            default: r_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: pops the scoreboard on each accepted beat and checks held beats.
    always @(negedge clk) begin
        if (!mon_en) begin
            first_pending = 1'b0;
            chk_ready     = 1'b0;
        end else begin
            if (chk_ready) begin
                check("ar_ready_after_last", ar_ready === 1'b1, $sformatf("ar_ready=%b want 1", ar_ready));
                chk_ready = 1'b0;
            end
            if (ar_valid === 1'b1 && ar_ready === 1'b1) begin
                t_ar          = cyc;
                first_pending = 1'b1;
            end
            if (r_valid === 1'b1 && first_pending) begin
                check("first_beat_latency", cyc == t_ar + 1 + int'(LAT),
                      $sformatf("first beat cycle %0d want %0d", cyc, t_ar + 1 + int'(LAT)));
                first_pending = 1'b0;
            end
            if (r_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    if (r_ready) check("unexpected_beat", 1'b0,
                                       $sformatf("beat data=%h with no request outstanding, want none", r_data));
                end else begin
                    mon_e = exp_q[0];
                    if (r_ready) begin
                        check("beat", {r_data, r_resp, r_last, r_id} === mon_e,
                              $sformatf("got data=%h resp=%0d last=%b id=%b want data=%h resp=%0d last=%b id=%b",
                                        r_data, r_resp, r_last, r_id, mon_e.data, mon_e.resp, mon_e.last, mon_e.id));
                        void'(exp_q.pop_front());
                        if (r_last) chk_ready = 1'b1;
                    end else begin
                        check("stall_beat", {r_data, r_resp, r_last, r_id} === mon_e,
                              $sformatf("got data=%h resp=%0d last=%b id=%b want data=%h resp=%0d last=%b id=%b",
                                        r_data, r_resp, r_last, r_id, mon_e.data, mon_e.resp, mon_e.last, mon_e.id));
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: still running at cycle %0d, want finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        ar_valid = 0; ar_id = '0; ar_addr = '0; ar_len = '0; ar_size = 3'b010; ar_burst = 2'b01;
        r_ready = 1'b1; bd_we = 0; bd_addr = '0; bd_wdata = '0;
        l0_ar_valid = 0; l0_ar_id = '0; l0_ar_addr = '0; l0_ar_len = '0; l0_ar_size = 3'b010;
        l0_ar_burst = 2'b01; l0_r_ready = 1'b1; l0_bd_we = 0; l0_bd_addr = '0; l0_bd_wdata = '0;

        repeat (3) step();
        check("reset_outputs", {ar_ready, r_valid, r_last, r_resp, r_data, r_id} === '0,
              $sformatf("ar_ready=%b r_valid=%b r_last=%b r_resp=%0d r_data=%h r_id=%b want all 0",
                        ar_ready, r_valid, r_last, r_resp, r_data, r_id));
        rst = 1'b1;
        step();
        step();
        check("ar_ready_after_reset", ar_ready === 1'b1 && l0_ar_ready === 1'b1,
              $sformatf("ar_ready=%b l0_ar_ready=%b want 1 1", ar_ready, l0_ar_ready));
        mon_en = 1'b1;

        for (int unsigned i = 0; i < 32'h400; i++)
            bd_write(i, (i >= 32'h100 && i <= 32'h10F) ? 32'(i) : $urandom);
        for (int unsigned i = 32'hFF0; i < 32'h1000; i++)
            bd_write(i, $urandom);

        // Directed cases
        rdy_mode = 0;
        issue(32'h400, 8'd7, 3'b010, 2'b01, 1'b0); drain();
        issue(32'h418, 8'd7, 3'b010, 2'b10, 1'b1); drain();
        rdy_mode = 1;
        issue(32'h400, 8'd7, 3'b010, 2'b01, 1'b0); drain();
        rdy_mode = 0;
        issue(32'h400, 8'd3, 3'b011, 2'b01, 1'b1); drain();
        issue(32'h3FF8, 8'd3, 3'b010, 2'b01, 1'b0); drain();

        // Zero-latency instance, single beat
        l0_bd_we = 1'b1; l0_bd_addr = 12'd5; l0_bd_wdata = 32'hCAFE0005;
        step();
        l0_bd_we = 1'b0;
        l0_ar_valid = 1'b1; l0_ar_addr = 32'h14; l0_ar_len = 8'd0; l0_ar_size = 3'b010;
        l0_ar_burst = 2'b01; l0_ar_id = 1'b1; l0_r_ready = 1'b1;
        @(negedge clk);
        check("l0_ar_ready", l0_ar_ready === 1'b1, $sformatf("l0_ar_ready=%b want 1", l0_ar_ready));
        step();
        l0_ar_valid = 1'b0;
        @(negedge clk);
        check("l0_first_beat", {l0_r_valid, l0_r_last, l0_r_data, l0_r_resp, l0_r_id} ===
                               {1'b1, 1'b1, 32'hCAFE0005, 2'b00, 1'b1},
              $sformatf("valid=%b last=%b data=%h resp=%0d id=%b want 1 1 cafe0005 0 1",
                        l0_r_valid, l0_r_last, l0_r_data, l0_r_resp, l0_r_id));
        step();
        @(negedge clk);
        check("l0_ready_after_last", l0_ar_ready === 1'b1 && l0_r_valid === 1'b0,
              $sformatf("ar_ready=%b r_valid=%b want 1 0", l0_ar_ready, l0_r_valid));
        step();

        // Randomized requests
        for (int t = 0; t < 40; t++) begin
            int unsigned w;
            logic [31:0] a;
            logic [7:0]  ln;
            logic [2:0]  sz;
            logic [1:0]  bu;
            int          sel;
            if ($urandom_range(0, 2) == 0)
                for (int k = 0; k < 3; k++) bd_write($urandom_range(0, 32'h3FF), $urandom);
            sel = $urandom_range(0, 7);
            bu  = (sel == 0) ? 2'b00 : (sel <= 4) ? 2'b01 : (sel <= 6) ? 2'b10 : 2'b11;
            if (bu == 2'b10 && $urandom_range(0, 3) != 0)
                ln = 8'((2 << $urandom_range(0, 3)) - 1);
            else
                ln = 8'($urandom_range(0, 15));
            sz = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'b010;
            w  = ($urandom_range(0, 3) == 0) ? 32'hFF0 + $urandom_range(0, 15) : $urandom_range(0, 32'h3E0);
            a  = (32'(w) << 2) | 32'($urandom_range(0, 3));
            rdy_mode = $urandom_range(0, 2);
            issue(a, ln, sz, bu, 1'($urandom_range(0, 1)));
            drain();
        end

        // Reset asserted while the third beat of a 16-beat burst is presented
        rdy_mode = 0;
        issue(32'h400, 8'd15, 3'b010, 2'b01, 1'b1);
        repeat (4) step();
        check("pre_reset_beat3", r_valid === 1'b1 && r_data === 32'h102,
              $sformatf("r_valid=%b r_data=%h want 1 00000102", r_valid, r_data));
        mon_en = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        check("reset_midburst", {ar_ready, r_valid, r_last, r_resp, r_data, r_id} === '0,
              $sformatf("ar_ready=%b r_valid=%b r_last=%b r_resp=%0d r_data=%h r_id=%b want all 0",
                        ar_ready, r_valid, r_last, r_resp, r_data, r_id));
        exp_q.delete();
        repeat (3) step();
        rst = 1'b1;
        step();
        step();
        check("no_partial_after_reset", r_valid === 1'b0 && ar_ready === 1'b1,
              $sformatf("r_valid=%b ar_ready=%b want 0 1", r_valid, ar_ready));
        mon_en = 1'b1;
        issue(32'h400, 8'd3, 3'b010, 2'b01, 1'b0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/icache_axi_responder.md
# icache_axi_responder

AXI4 read-only responder (slave) answering the instruction-cache refill port: accepts one AR request at a time, waits a programmable latency, then returns the burst on the R channel from an internal word array. Serves as the memory model / boot-ROM endpoint behind the front-end `ICacheAxi` interface in simulation and FPGA bring-up. A backdoor write port preloads program images.

## Interface
- `DATA_WIDTH`, 32: R data width; also the only legal beat size, so `ar_size` must equal 3'b010.
- `ADDR_WIDTH`, 32: AR address width.
- `ID_WIDTH`, 1: AR/R id width.
- `MEM_DEPTH`, 4096: number of `DATA_WIDTH` words; power of two.
- `READ_LATENCY`, 2: idle cycles between AR handshake and first R beat; legal range 0..15.
- `clk`  in  1  sole clock, all logic on its rising edge.
- `rst`  in  1  reset, asynchronous, active-low (asserted at 0).
- `ar_valid`  in  1  request valid.
- `ar_ready`  out  1  request accepted when high with `ar_valid`.
- `ar_id`  in  ID_WIDTH  request id.
- `ar_addr`  in  ADDR_WIDTH  byte address of first beat.
- `ar_len`  in  8  beats minus one.
- `ar_size`  in  3  beat size.
- `ar_burst`  in  2  00 FIXED, 01 INCR, 10 WRAP.
- `r_valid`  out  1  beat valid.
- `r_ready`  in  1  beat accepted when high with `r_valid`.
- `r_id`  out  ID_WIDTH  echoes captured `ar_id`.
- `r_data`  out  DATA_WIDTH  beat data.
- `r_resp`  out  2  00 OKAY, 10 SLVERR, 11 DECERR.
- `r_last`  out  1  high on final beat.
- `bd_we`  in  1  backdoor word write enable.
- `bd_addr`  in  $clog2(MEM_DEPTH)  backdoor word index.
- `bd_wdata`  in  DATA_WIDTH  backdoor data.

## Operation
- States IDLE, WAIT, BURST. Only one request in flight.
- IDLE: `ar_ready`=1. On `ar_valid`: capture id, word address (`ar_addr>>2`), len, burst; clear beat counter; go to WAIT if `READ_LATENCY`>0, else BURST. Latency counter loads `READ_LATENCY-1`.
- WAIT: `ar_ready`=0; decrement counter, go to BURST when it reads 0.
- BURST: `r_valid`=1; present the current beat from a holding register. On `r_ready`: advance the address and counter and load the next beat. The beat with counter == len carries `r_last`=1; its acceptance returns the block to IDLE.
- Address advance:
  - FIXED keeps the address.
  - INCR adds 1 word.
  - WRAP adds 1 within an aligned window of (len+1) words. Lower bits wrap and upper bits are held.
- Errors are evaluated per request and returned on every beat, with data 0. The burst length is still honoured.
  - `ar_size`≠010, or WRAP with len not in {1,3,7,15}, or burst 11: SLVERR.
  - Otherwise, a beat whose word index ≥ `MEM_DEPTH`: DECERR for that beat.
- Backdoor write: the array is updated at the clock edge. It is legal in any state. A beat already in the holding register is not altered.

## Timing
- Reset values: `ar_ready`=1 once reset deasserts, 0 during reset; `r_valid`=0, `r_last`=0, `r_resp`=0, `r_data`=0, `r_id`=0; state IDLE. Array contents are not reset.
- AR handshake in cycle T: first `r_valid` in cycle T+1+`READ_LATENCY`.
- With `r_ready` held high, beats are back-to-back, one per cycle. A burst of len+1 beats ends at T+1+`READ_LATENCY`+len.
- With `r_valid`=1 and `r_ready`=0: `r_data`, `r_resp`, `r_last` and `r_id` stay stable.
- The cycle after the last-beat handshake: IDLE, `ar_ready`=1. There is no AR acceptance in the same cycle as the last beat.
- A backdoor write in cycle C to word W becomes visible to beats loaded from C+1 onward.
- Reset asserted mid-burst: outputs go to reset values immediately (asynchronously) and the burst is discarded. There is no partial completion after deassert.
- Wrap-around: the INCR word address is `ADDR_WIDTH-2` bits wide and rolls over naturally. The out-of-range check uses the full index.

## Structure
- The shared package holds the `AxiBurst` and `AxiResp` enums, the response constants, and the responder state enum.
- One sub-module, `axi_resp_mem`: a `MEM_DEPTH`×`DATA_WIDTH` array with one read port and one write port, both synchronous, with write-first disabled.
- The address generator (FIXED/INCR/WRAP) stays inline as a function.

## Test plan
- Preload words 0x100..0x10F with their index; AR addr 0x400, len 7, INCR, latency 2, `r_ready`=1. Expected: beats start 3 cycles after the handshake, data 0x100..0x107, `r_last` on the 8th beat, OKAY.
- WRAP, addr 0x418, len 7: data words 0x106, 0x107, 0x100..0x105.
- Same INCR burst with `r_ready` toggling 1,0,0,1 each beat. Expected: each beat held stable, 8 beats total, no duplicated or dropped beat.
- `ar_size`=011, len 3: four beats of SLVERR, data 0, last on beat 4. Then AR at `MEM_DEPTH`*4-8, len 3: OKAY, OKAY, DECERR, DECERR.
- `READ_LATENCY`=0, len 0: `r_valid` with `r_last` in the cycle after the handshake, and `ar_ready` high the following cycle.
- Assert `rst`=0 during beat 3 of a 16-beat burst. Expected: `r_valid` drops immediately. After release, a new request is served correctly from beat 0.
